// File: rtl/cv32e40px_apu_core_pkg.sv
// APU width constants shared by the core and the APU dispatcher, plus the
// order-tag encoding used to mark operations that target no real unit.
package cv32e40px_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU     = 3;
    localparam int unsigned APU_WOP_CPU       = 6;
    localparam int unsigned APU_NDSFLAGS_CPU  = 15;
    localparam int unsigned APU_NUSFLAGS_CPU  = 5;

    // Upper bound on the number of units one dispatcher can serve
    localparam int unsigned NUM_APU_UNITS_MAX = 8;

    // MSB of every order-FIFO entry: real unit, or a dummy entry that retires with zeros
    typedef enum logic {
        APU_TAG_UNIT  = 1'b0,
        APU_TAG_DUMMY = 1'b1
    } apu_tag_e;

    // Next value of a per-unit clock-gate hold counter
    function automatic logic [3:0] hold_next(input logic active, input logic [3:0] hold, input logic [3:0] reload);
        logic [3:0] nxt;
        if (active) begin
            nxt = reload;
        end else if (hold != 4'd0) begin
            nxt = hold - 4'd1;
        end else begin
            nxt = 4'd0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cv32e40px_apu_res_fifo.sv
// Small synchronous FIFO; read data is valid whenever the FIFO is not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module cv32e40px_apu_res_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    assign empty_o = (cnt_q == CW'(0));
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign rdata_o = mem_q[rptr_q];

    // Qualify push/pop against the current fill level
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
    end

    // Storage, pointers and fill count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop_s) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40px_apu_mux.sv
// APU dispatcher: routes core requests to one of NUM_UNITS accelerators,
// buffers their results per unit and returns them to the core in issue order.
module cv32e40px_apu_mux
    import cv32e40px_apu_core_pkg::*;
#(
    parameter int unsigned NUM_UNITS       = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned RES_DEPTH       = 2,
    parameter int unsigned CG_HOLD         = 3
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            apu_req_i,
    output logic                                            apu_gnt_o,
    input  logic [$clog2(NUM_UNITS+1)-1:0]                  apu_unit_i,
    input  logic [APU_NARGS_CPU-1:0][31:0]                  apu_operands_i,
    input  logic [APU_WOP_CPU-1:0]                          apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]                     apu_flags_i,
    output logic                                            apu_rvalid_o,
    output logic [31:0]                                     apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                     apu_flags_o,
    output logic                                            apu_busy_o,
    output logic [NUM_UNITS-1:0]                            unit_req_o,
    input  logic [NUM_UNITS-1:0]                            unit_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                  unit_operands_o,
    output logic [APU_WOP_CPU-1:0]                          unit_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                     unit_flags_o,
    input  logic [NUM_UNITS-1:0]                            unit_rvalid_i,
    input  logic [NUM_UNITS-1:0][31:0]                      unit_result_i,
    input  logic [NUM_UNITS-1:0][APU_NUSFLAGS_CPU-1:0]      unit_rflags_i,
    output logic [NUM_UNITS-1:0]                            unit_clk_en_o
);

    localparam int unsigned IW = $clog2(NUM_UNITS + 1);
    localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned OW = UW + 1;
    localparam int unsigned RW = 32 + APU_NUSFLAGS_CPU;
    localparam int unsigned CW = $clog2(RES_DEPTH + 1);

    logic                            order_full_s;
    logic                            order_empty_s;
    logic                            order_push_s;
    logic                            order_pop_s;
    logic [OW-1:0]                   order_wdata_s;
    logic [OW-1:0]                   order_head_s;
    logic                            head_dummy_s;
    logic [UW-1:0]                   head_unit_s;
    logic                            unit_valid_s;
    logic                            order_block_s;
    logic                            sel_full_s;
    logic                            stall_s;
    logic                            retire_s;
    logic [NUM_UNITS-1:0]            head_sel_s;
    logic [NUM_UNITS-1:0]            issue_s;
    logic [NUM_UNITS-1:0]            dec_s;
    logic [NUM_UNITS-1:0]            res_push_s;
    logic [NUM_UNITS-1:0]            res_pop_s;
    logic [NUM_UNITS-1:0]            res_empty_s;
    logic [NUM_UNITS-1:0]            res_full_s;
    logic [NUM_UNITS-1:0][RW-1:0]    res_rdata_s;
    logic [NUM_UNITS-1:0][CW-1:0]    out_cnt_q;
    logic [NUM_UNITS-1:0][CW-1:0]    out_cnt_d;
    logic [NUM_UNITS-1:0][3:0]       hold_q;
    logic [NUM_UNITS-1:0][3:0]       hold_d;

    assign unit_operands_o = apu_operands_i;
    assign unit_op_o       = apu_op_i;
    assign unit_flags_o    = apu_flags_i;
    assign apu_busy_o      = ~order_empty_s | apu_req_i;

    // Order FIFO: target unit (or dummy tag) of every accepted operation
    cv32e40px_apu_res_fifo #(
        .WIDTH (OW),
        .DEPTH (MAX_OUTSTANDING)
    ) i_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (order_push_s),
        .pop_i   (order_pop_s),
        .wdata_i (order_wdata_s),
        .rdata_o (order_head_s),
        .empty_o (order_empty_s),
        .full_o  (order_full_s)
    );

    // Per-unit result buffers
    for (genvar u = 0; u < int'(NUM_UNITS); u++) begin : g_res
        cv32e40px_apu_res_fifo #(
            .WIDTH (RW),
            .DEPTH (RES_DEPTH)
        ) i_res_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (res_push_s[u]),
            .pop_i   (res_pop_s[u]),
            .wdata_i ({unit_rflags_i[u], unit_result_i[u]}),
            .rdata_o (res_rdata_s[u]),
            .empty_o (res_empty_s[u]),
            .full_o  (res_full_s[u])
        );
    end

    // Retire path: head entry selection, bypass and result mux
    always_comb begin
        head_dummy_s = (order_head_s[OW-1] == APU_TAG_DUMMY);
        head_unit_s  = order_head_s[UW-1:0];
        retire_s     = ~order_empty_s & head_dummy_s;
        apu_result_o = 32'd0;
        apu_flags_o  = '0;
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            head_sel_s[u] = ~order_empty_s & ~head_dummy_s & (head_unit_s == UW'(u));
            dec_s[u]      = head_sel_s[u] & (~res_empty_s[u] | unit_rvalid_i[u]);
            res_pop_s[u]  = head_sel_s[u] & ~res_empty_s[u];
            // A strobe with nothing outstanding is dropped; a bypassed one skips the buffer
            res_push_s[u] = unit_rvalid_i[u] & (out_cnt_q[u] != CW'(0))
                            & ~(head_sel_s[u] & res_empty_s[u]);
            if (dec_s[u]) begin
                retire_s = 1'b1;
                if (!res_empty_s[u]) begin
                    apu_result_o = res_rdata_s[u][31:0];
                    apu_flags_o  = res_rdata_s[u][RW-1:32];
                end else begin
                    apu_result_o = unit_result_i[u];
                    apu_flags_o  = unit_rflags_i[u];
                end
            end else begin
                retire_s = retire_s;
            end
        end
        apu_rvalid_o = retire_s;
        order_pop_s  = retire_s;
    end

    // Issue path: stall evaluation, request routing and grant
    always_comb begin
        unit_valid_s = (apu_unit_i < IW'(NUM_UNITS));
        // A retiring head frees its order slot in time for a same-cycle grant
        order_block_s = order_full_s & ~retire_s;
        sel_full_s    = 1'b0;
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            sel_full_s = sel_full_s
                         | ((apu_unit_i == IW'(u)) & (out_cnt_q[u] == CW'(RES_DEPTH)));
        end
        stall_s = order_block_s | sel_full_s;
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            unit_req_o[u] = apu_req_i & ~stall_s & unit_valid_s & (apu_unit_i == IW'(u));
            issue_s[u]    = unit_req_o[u] & unit_gnt_i[u];
        end
        if (unit_valid_s) begin
            apu_gnt_o     = |issue_s;
            order_wdata_s = {APU_TAG_UNIT, apu_unit_i[UW-1:0]};
        end else begin
            apu_gnt_o     = apu_req_i & ~order_block_s;
            order_wdata_s = {APU_TAG_DUMMY, apu_unit_i[UW-1:0]};
        end
        order_push_s = apu_gnt_o;
    end

    // Next-state of outstanding counters, hold counters and clock enables
    always_comb begin
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            case ({issue_s[u], dec_s[u]})
                2'b10:   out_cnt_d[u] = out_cnt_q[u] + CW'(1);
                2'b01:   out_cnt_d[u] = out_cnt_q[u] - CW'(1);
                default: out_cnt_d[u] = out_cnt_q[u];
            endcase
            hold_d[u] = hold_next(unit_req_o[u] | (out_cnt_q[u] != CW'(0)), hold_q[u], 4'(CG_HOLD));
            unit_clk_en_o[u] = unit_req_o[u] | (out_cnt_q[u] != CW'(0)) | (hold_q[u] != 4'd0);
        end
    end

    // Per-unit counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_cv32e40px_apu_mux.sv
// Randomised and directed bench for the APU dispatcher; the bench plays the
// core and every unit, and predicts outputs from an in-order operation list.
module tb_cv32e40px_apu_mux;
    import cv32e40px_apu_core_pkg::*;

    localparam int N    = 2;
    localparam int MAXO = 4;
    localparam int RD   = 2;
    localparam int CGH  = 3;
    localparam int IW   = $clog2(N + 1);
    localparam int NF   = APU_NUSFLAGS_CPU;
    localparam int BAD  = 3;

    logic                               clk_i = 1'b0;
    logic                               rst_ni = 1'b0;
    logic                               apu_req_i;
    logic                               apu_gnt_o;
    logic [IW-1:0]                      apu_unit_i;
    logic [APU_NARGS_CPU-1:0][31:0]     apu_operands_i;
    logic [APU_WOP_CPU-1:0]             apu_op_i;
    logic [APU_NDSFLAGS_CPU-1:0]        apu_flags_i;
    logic                               apu_rvalid_o;
    logic [31:0]                        apu_result_o;
    logic [NF-1:0]                      apu_flags_o;
    logic                               apu_busy_o;
    logic [N-1:0]                       unit_req_o;
    logic [N-1:0]                       unit_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]     unit_operands_o;
    logic [APU_WOP_CPU-1:0]             unit_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]        unit_flags_o;
    logic [N-1:0]                       unit_rvalid_i;
    logic [N-1:0][31:0]                 unit_result_i;
    logic [N-1:0][NF-1:0]               unit_rflags_i;
    logic [N-1:0]                       unit_clk_en_o;

    always #5 clk_i = ~clk_i;

    cv32e40px_apu_mux #(
        .NUM_UNITS(N), .MAX_OUTSTANDING(MAXO), .RES_DEPTH(RD), .CG_HOLD(CGH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o), .apu_unit_i(apu_unit_i),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rvalid_o(apu_rvalid_o), .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
        .apu_busy_o(apu_busy_o), .unit_req_o(unit_req_o), .unit_gnt_i(unit_gnt_i),
        .unit_operands_o(unit_operands_o), .unit_op_o(unit_op_o), .unit_flags_o(unit_flags_o),
        .unit_rvalid_i(unit_rvalid_i), .unit_result_i(unit_result_i),
        .unit_rflags_i(unit_rflags_i), .unit_clk_en_o(unit_clk_en_o)
    );

    typedef struct {
        int            due;
        logic [31:0]   d;
        logic [NF-1:0] f;
    } resp_t;

    int    tests = 0;
    int    failed = 0;
    int    cyc = 0;
    int    ord_q[$];          // unit of every accepted op in issue order, -1 = invalid index
    resp_t buf_q[N][$];       // results delivered by a unit but not yet returned to the core
    resp_t pend_q[N][$];      // results a unit still has to deliver
    int    last_act[N];
    int    lat_force[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int cnt_of(input int u);
        int c = 0;
        foreach (ord_q[i]) if (ord_q[i] == u) c++;
        return c;
    endfunction

    task automatic clear_model();
        ord_q.delete();
        for (int u = 0; u < N; u++) begin
            buf_q[u].delete();
            pend_q[u].delete();
            last_act[u] = -100;
        end
    endtask

    // One clock cycle: drive at posedge+1, predict and check at negedge, advance model
    task automatic step(input bit req, input int unit, input logic [N-1:0] ugnt, input logic [N-1:0] inj);
        logic [N-1:0]  rv;
        logic [31:0]   rin[N];
        logic [NF-1:0] fin[N];
        int            cb[N];
        int            h;
        bit            ret;
        bit            from_buf;
        bit            ostall;
        bit            egnt;
        logic [31:0]   er;
        logic [NF-1:0] ef;
        logic [N-1:0]  ereq;
        logic [N-1:0]  een;
        int            lat;
        resp_t         r;

        apu_req_i      = req;
        apu_unit_i     = IW'(unit);
        apu_operands_i = {$urandom, $urandom, $urandom};
        apu_op_i       = APU_WOP_CPU'($urandom);
        apu_flags_i    = APU_NDSFLAGS_CPU'($urandom);
        unit_gnt_i     = ugnt;
        rv = '0;
        for (int u = 0; u < N; u++) begin
            rin[u] = $urandom;
            fin[u] = NF'($urandom);
            if (pend_q[u].size() > 0 && pend_q[u][0].due <= cyc) begin
                r = pend_q[u].pop_front();
                rv[u] = 1'b1; rin[u] = r.d; fin[u] = r.f;
            end else if (inj[u]) begin
                rv[u] = 1'b1;
            end
            unit_result_i[u] = rin[u];
            unit_rflags_i[u] = fin[u];
            cb[u] = cnt_of(u);
        end
        unit_rvalid_i = rv;

        @(negedge clk_i);
        ret = 0; from_buf = 0; h = -2; er = '0; ef = '0;
        if (ord_q.size() > 0) begin
            h = ord_q[0];
            if (h < 0) ret = 1;
            else if (buf_q[h].size() > 0) begin ret = 1; from_buf = 1; er = buf_q[h][0].d; ef = buf_q[h][0].f; end
            else if (rv[h]) begin ret = 1; er = rin[h]; ef = fin[h]; end
        end
        ostall = (ord_q.size() == MAXO) && !ret;
        ereq = '0; egnt = 0;
        if (req && !ostall) begin
            if (unit < N) begin
                if (cb[unit] < RD) begin ereq[unit] = 1'b1; egnt = ugnt[unit]; end
            end else begin
                egnt = 1;
            end
        end
        for (int u = 0; u < N; u++)
            een[u] = ereq[u] | (cb[u] > 0) | ((cyc - last_act[u]) <= CGH);

        check("gnt", 64'(apu_gnt_o), 64'(egnt));
        check("unit_req", 64'(unit_req_o), 64'(ereq));
        check("rvalid", 64'(apu_rvalid_o), 64'(ret));
        if (ret) begin
            check("result", 64'(apu_result_o), 64'(er));
            check("rflags", 64'(apu_flags_o), 64'(ef));
        end
        check("busy", 64'(apu_busy_o), 64'((ord_q.size() > 0) || req));
        check("clk_en", 64'(unit_clk_en_o), 64'(een));
        check("bcast_op", 64'({unit_op_o, unit_operands_o[0]}), 64'({apu_op_i, apu_operands_i[0]}));

        if (ret) begin
            void'(ord_q.pop_front());
            if (from_buf) void'(buf_q[h].pop_front());
        end
        for (int u = 0; u < N; u++) begin
            if (rv[u] && !(ret && u == h && !from_buf) && cb[u] > 0) begin
                r.due = 0; r.d = rin[u]; r.f = fin[u];
                buf_q[u].push_back(r);
            end
            if (ereq[u] || cb[u] > 0) last_act[u] = cyc;
        end
        if (egnt) begin
            ord_q.push_back((unit < N) ? unit : -1);
            if (unit < N) begin
                lat = (lat_force[unit] > 0) ? lat_force[unit] : $urandom_range(1, 6);
                r.due = cyc + lat;
                if (pend_q[unit].size() > 0 && r.due <= pend_q[unit][$].due)
                    r.due = pend_q[unit][$].due + 1;
                r.d = $urandom; r.f = NF'($urandom);
                pend_q[unit].push_back(r);
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '1, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 64'(apu_gnt_o), 64'd0);
        check({tag, "_rvalid"}, 64'(apu_rvalid_o), 64'd0);
        check({tag, "_busy"}, 64'(apu_busy_o), 64'd0);
        check({tag, "_unit_req"}, 64'(unit_req_o), 64'd0);
        check({tag, "_clk_en"}, 64'(unit_clk_en_o), 64'd0);
        check({tag, "_result"}, 64'(apu_result_o), 64'd0);
        check({tag, "_flags"}, 64'(apu_flags_o), 64'd0);
    endtask

    initial begin
        apu_req_i = 1'b0; apu_unit_i = '0; apu_operands_i = '0; apu_op_i = '0;
        apu_flags_i = '0; unit_gnt_i = '0; unit_rvalid_i = '0;
        unit_result_i = '0; unit_rflags_i = '0;
        for (int u = 0; u < N; u++) lat_force[u] = 0;
        clear_model();

        // Power-on reset
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single unit, latency 2, three back-to-back ops
        lat_force[0] = 2;
        repeat (3) step(1'b1, 0, '1, '0);
        idle(10);

        // Reordering: slow unit0 op ahead of fast unit1 op
        lat_force[0] = 5; lat_force[1] = 1;
        step(1'b1, 0, '1, '0);
        step(1'b1, 1, '1, '0);
        idle(10);

        // Buffer stall: unit1 result buffer fills behind a slow unit0 head
        lat_force[0] = 8; lat_force[1] = 1;
        step(1'b1, 0, '1, '0);
        repeat (12) step(1'b1, 1, '1, '0);
        idle(12);

        // Order FIFO full, fifth request is an invalid index
        lat_force[0] = 6; lat_force[1] = 6;
        step(1'b1, 0, '1, '0);
        step(1'b1, 1, '1, '0);
        step(1'b1, 0, '1, '0);
        step(1'b1, 1, '1, '0);
        repeat (8) step(1'b1, BAD, '1, '0);
        idle(12);

        // Lone invalid index
        step(1'b1, BAD, '1, '0);
        idle(4);

        // Randomised traffic
        lat_force[0] = 0; lat_force[1] = 0;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 8) ? $urandom_range(0, N - 1) : BAD,
                 {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)},
                 '0);
        end
        idle(20);

        // Reset with three ops outstanding, then stray unit strobes
        lat_force[0] = 10; lat_force[1] = 10;
        step(1'b1, 0, '1, '0);
        step(1'b1, 1, '1, '0);
        step(1'b1, 0, '1, '0);
        apu_req_i = 1'b0; unit_gnt_i = '0; unit_rvalid_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cyc++;
        repeat (3) step(1'b0, 0, '1, '1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
